// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory-port arbiter.
//   state_t  - arbiter FSM states (IDLE / ISSUE / WAIT)
//   OWNER_IF - owner encoding for the instruction-fetch port
//   OWNER_D  - owner encoding for the load/store port
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_grant.sv
// mem_arbiter_grant: winner select between fetch and data requests.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (alternating priority
// on contested grants; the first contest after reset goes to data).
// Ports:
//   clk, reset   - clock / async active-high reset (round-robin build only)
//   grant_en     - arbiter may grant this cycle (IDLE, not in reset)
//   if_req       - fetch request
//   d_req        - data request
//   grant_valid  - a request is granted this cycle
//   grant_d      - winner is the data port (valid with grant_valid)
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic grant_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_valid,
  output logic grant_d
);

  // prio_d = 1: data wins the next contest
  logic prio_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Pointer flips only when both ports competed for the same grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_d <= OWNER_D;
    end else if (grant_en && if_req && d_req) begin
      prio_d <= ~prio_d;
    end
  end
`else
  assign prio_d = OWNER_D;
`endif

  assign grant_valid = grant_en & (if_req | d_req);
  assign grant_d     = d_req & (prio_d | ~if_req);

endmodule : mem_arbiter_grant

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU fetch and load/store.
// One transaction outstanding at a time: IDLE grants and latches the
// request, ISSUE holds mem_req until mem_ready, WAIT returns mem_rvalid /
// mem_rdata to the owning port.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (see mem_arbiter_grant).
// Ports:
//   clk, reset                      - clock, async active-high reset
//   if_req/if_addr                  - fetch request in
//   if_ready/if_rvalid/if_rdata     - fetch accept / response out
//   d_req/d_we/d_wstrb/d_addr/d_wdata - data request in
//   d_ready/d_rvalid/d_rdata        - data accept / response out
//   mem_req/mem_we/mem_wstrb/mem_addr/mem_wdata - memory request out
//   mem_ready/mem_rvalid/mem_rdata  - memory accept / response in
//   owner                           - 0 fetch, 1 data (current or last)
//   busy                            - FSM not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    owner,
  output logic                    busy
);

  state_t state;
  logic   grant_en;
  logic   grant_valid;
  logic   grant_d;
  logic   rsp;

  // Grants are blocked while reset is held so x_ready reads 0 in reset
  assign grant_en = (state == ST_IDLE) & ~reset;

  mem_arbiter_grant u_grant (
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    .clk         (clk),
    .reset       (reset),
`endif
    .grant_en    (grant_en),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant_d     (grant_d)
  );

  // FSM with latched request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWNER_IF;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner <= grant_d;
            state <= ST_ISSUE;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_wstrb <= d_wstrb;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              // Fetches are always reads
              mem_we    <= 1'b0;
              mem_wstrb <= '0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req = (state == ST_ISSUE);
  assign busy    = (state != ST_IDLE);

  assign if_ready = grant_valid & ~grant_d;
  assign d_ready  = grant_valid &  grant_d;

  // Responses only count in WAIT; route to the owner, zero elsewhere
  assign rsp       = (state == ST_WAIT) & mem_rvalid;
  assign if_rvalid = rsp & (owner == OWNER_IF);
  assign d_rvalid  = rsp & (owner == OWNER_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid & ~mem_we) ? mem_rdata : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 unit later, well clear of the next edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        owner, busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_wstrb    (d_wstrb),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .owner      (owner),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset values (fetch request present but not granted in reset)
    cyc(); cyc();
    if_req = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_rdata", d_rdata, 0);
    cyc(); reset = 1'b0; if_req = 1'b0;

    // 1. Fetch read, zero-wait memory
    cyc(); if_req = 1'b1; if_addr = 32'h8;
    #1; chk("t1_if_ready", if_ready, 1); chk("t1_d_ready", d_ready, 0);
    cyc(); if_req = 1'b0; mem_ready = 1'b1;
    #1; chk("t1_mem_req", mem_req, 1); chk("t1_mem_addr", mem_addr, 32'h8);
    chk("t1_owner", owner, 0); chk("t1_mem_we", mem_we, 0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
    #1; chk("t1_if_rvalid", if_rvalid, 1); chk("t1_if_rdata", if_rdata, 32'h13);
    chk("t1_d_rvalid", d_rvalid, 0); chk("t1_d_rdata", d_rdata, 0);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t1_idle_busy", busy, 0); chk("t1_if_rvalid_off", if_rvalid, 0);

    // 2. Data write
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    #1; chk("t2_d_ready", d_ready, 1); chk("t2_if_ready", if_ready, 0);
    cyc(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0; mem_ready = 1'b1;
    #1; chk("t2_mem_we", mem_we, 1); chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF); chk("t2_mem_wstrb", mem_wstrb, 4'hF);
    chk("t2_owner", owner, 1);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1; chk("t2_d_rvalid", d_rvalid, 1); chk("t2_d_rdata", d_rdata, 0);
    chk("t2_if_rvalid", if_rvalid, 0);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t2_d_rvalid_off", d_rvalid, 0);

    // 3. Contention: data first, fetch at cycle 3
    cyc(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h200;
    #1; chk("t3_d_ready", d_ready, 1); chk("t3_if_ready", if_ready, 0);
    cyc(); d_req = 1'b0; mem_ready = 1'b1;
    #1; chk("t3_owner_d", owner, 1); chk("t3_mem_addr_d", mem_addr, 32'h200);
    chk("t3_if_wait", if_ready, 0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5;
    #1; chk("t3_d_rvalid", d_rvalid, 1); chk("t3_d_rdata", d_rdata, 32'hA5A5);
    chk("t3_if_rvalid_no", if_rvalid, 0);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t3_if_ready_c3", if_ready, 1);
    cyc(); if_req = 1'b0; mem_ready = 1'b1;
    #1; chk("t3_owner_if", owner, 0); chk("t3_mem_addr_if", mem_addr, 32'h40);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1; chk("t3_if_rvalid", if_rvalid, 1); chk("t3_if_rdata", if_rdata, 32'h77);
    chk("t3_d_rvalid_no", d_rvalid, 0);
    cyc(); mem_rvalid = 1'b0;
    // Second contest: fetch wins under round-robin, data otherwise
    cyc(); if_req = 1'b1; d_req = 1'b1;
    #1; chk("t3b_if_ready", if_ready, RR); chk("t3b_d_ready", d_ready, !RR);
    cyc(); if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    #1; chk("t3b_owner", owner, !RR);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1;
    cyc(); mem_rvalid = 1'b0;

    // 4. Wait states: mem_ready low 3 cycles, response 2 cycles after accept
    cyc(); if_req = 1'b1; if_addr = 32'h80;
    #1; chk("t4_if_ready", if_ready, 1);
    cyc(); if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("t4_mem_req_hold", mem_req, 1); chk("t4_mem_addr_hold", mem_addr, 32'h80);
      chk("t4_no_rvalid", if_rvalid, 0);
      cyc();
    end
    mem_ready = 1'b1;
    #1; chk("t4_mem_req_acc", mem_req, 1); chk("t4_mem_addr_acc", mem_addr, 32'h80);
    cyc(); mem_ready = 1'b0;
    #1; chk("t4_wait_mem_req", mem_req, 0); chk("t4_wait_busy", busy, 1);
    chk("t4_wait_rvalid", if_rvalid, 0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1; chk("t4_if_rvalid", if_rvalid, 1); chk("t4_if_rdata", if_rdata, 32'h99);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t4_rvalid_once", if_rvalid, 0); chk("t4_idle", busy, 0);

    // 5. Reset during WAIT, late response ignored
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    #1; chk("t5_d_ready", d_ready, 1);
    cyc(); d_req = 1'b0; mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0;
    #1; chk("t5_in_wait", busy, 1); chk("t5_wait_mem_req", mem_req, 0);
    reset = 1'b1;
    #1; chk("t5_rst_busy", busy, 0); chk("t5_rst_owner", owner, 0);
    chk("t5_rst_mem_addr", mem_addr, 0); chk("t5_rst_d_rvalid", d_rvalid, 0);
    cyc(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1; chk("t5_late_d_rvalid", d_rvalid, 0); chk("t5_late_if_rvalid", if_rvalid, 0);
    chk("t5_late_d_rdata", d_rdata, 0); chk("t5_late_busy", busy, 0);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t5_after_busy", busy, 0);

    // 6. Stray response in IDLE
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hFF;
    #1; chk("t6_if_rvalid", if_rvalid, 0); chk("t6_d_rvalid", d_rvalid, 0);
    chk("t6_busy", busy, 0);
    cyc(); mem_rvalid = 1'b0;
    #1; chk("t6_still_idle", busy, 0); chk("t6_mem_req", mem_req, 0);

    // First contest after reset goes to data in either build
    cyc(); if_req = 1'b1; d_req = 1'b1; d_addr = 32'h400;
    #1; chk("t6_contest_d", d_ready, 1); chk("t6_contest_if", if_ready, 0);
    cyc(); if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1;
    cyc(); mem_rvalid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_arbiter
